// File: rtl/load_align_if.sv
// rtl/load_align_if.sv - load request, memory read and writeback bus for load_align_unit
//
// Purpose: groups the load unit's handshake and data signals.
//   req_*      : load request from EX (opcode, effective address, rt_old)
//   mem_*      : word-aligned read address/request and read-data handshake
//   wb_*       : aligned/extended/merged rt writeback value
// Modports:
//   master : the environment side (EX stage, memory, register file)
//   slave  : the load_align_unit side
interface load_align_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       rt_old;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_addr_ready;
    logic [31:0]       mem_rdata;
    logic              mem_rdata_valid;
    logic              mem_rdata_ready;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;

    modport master (
        output req_valid, opcode, addr, rt_old,
        output mem_addr_ready, mem_rdata, mem_rdata_valid,
        output wb_ready,
        input  req_ready, mem_addr, mem_rd, mem_rdata_ready,
        input  wb_valid, wb_data
    );

    modport slave (
        input  req_valid, opcode, addr, rt_old,
        input  mem_addr_ready, mem_rdata, mem_rdata_valid,
        input  wb_ready,
        output req_ready, mem_addr, mem_rd, mem_rdata_ready,
        output wb_valid, wb_data
    );
endinterface

// File: rtl/load_align_unit.sv
// rtl/load_align_unit.sv - single-load-in-flight read issue and rt alignment/merge
//
// Purpose: accepts one load from EX, issues a word-aligned memory read, waits
// for the read data, then extracts/extends (lb/lbu/lh/lhu/lw) or merges with
// rt_old (lwl/lwr) and presents the result for register writeback.
// Ports:
//   clk   in  : clock, rising edge
//   rst   in  : asynchronous reset, active-high
//   bus   slave modport of load_align_if:
//     req_valid/req_ready, opcode, addr, rt_old      : load request
//     mem_addr, mem_rd/mem_addr_ready                : read address phase
//     mem_rdata, mem_rdata_valid/mem_rdata_ready     : read data phase
//     wb_data, wb_valid/wb_ready                     : writeback
module load_align_unit #(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    load_align_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LWL = 6'b100010;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWR = 6'b100110;

    logic [1:0]        state_q,    state_d;
    logic [5:0]        opcode_q,   opcode_d;
    logic [1:0]        ea_q,       ea_d;
    logic [31:0]       rt_old_q,   rt_old_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       wb_data_q,  wb_data_d;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       result;

    // Byte/halfword picked out of the returned word by the captured offset.
    // Halfword selection looks only at ea[1]; misaligned lh/lhu are not trapped here.
    always_comb begin
        byte_sel = 8'h00;
        case (ea_q)
            2'd0: byte_sel = bus.mem_rdata[7:0];
            2'd1: byte_sel = bus.mem_rdata[15:8];
            2'd2: byte_sel = bus.mem_rdata[23:16];
            2'd3: byte_sel = bus.mem_rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = ea_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    end

    // Writeback value. lwl fills rt from the top down with the low bytes of
    // the word; lwr fills rt from the bottom up with the high bytes.
    always_comb begin
        result = bus.mem_rdata;
        case (opcode_q)
            OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: result = {24'h000000, byte_sel};
            OP_LH:  result = {{16{half_sel[15]}}, half_sel};
            OP_LHU: result = {16'h0000, half_sel};
            OP_LWL: begin
                case (ea_q)
                    2'd0: result = {bus.mem_rdata[7:0],  rt_old_q[23:0]};
                    2'd1: result = {bus.mem_rdata[15:0], rt_old_q[15:0]};
                    2'd2: result = {bus.mem_rdata[23:0], rt_old_q[7:0]};
                    default: result = bus.mem_rdata;
                endcase
            end
            OP_LWR: begin
                case (ea_q)
                    2'd0: result = bus.mem_rdata;
                    2'd1: result = {rt_old_q[31:24], bus.mem_rdata[31:8]};
                    2'd2: result = {rt_old_q[31:16], bus.mem_rdata[31:16]};
                    default: result = {rt_old_q[31:8], bus.mem_rdata[31:24]};
                endcase
            end
            default: result = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        ea_d       = ea_q;
        rt_old_d   = rt_old_q;
        mem_addr_d = mem_addr_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    opcode_d   = bus.opcode;
                    ea_d       = bus.addr[1:0];
                    rt_old_d   = bus.rt_old;
                    mem_addr_d = {bus.addr[ADDR_W-1:2], 2'b00};
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // Read data seen alongside the address handshake is not
                // consumed; the memory must present it again in DATA.
                if (bus.mem_addr_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.mem_rdata_valid) begin
                    wb_data_d = result;
                    state_d   = ST_WB;
                end
            end
            ST_WB: begin
                if (bus.wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            opcode_q   <= '0;
            ea_q       <= '0;
            rt_old_q   <= '0;
            mem_addr_q <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            ea_q       <= ea_d;
            rt_old_q   <= rt_old_d;
            mem_addr_q <= mem_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Moore outputs
    assign bus.req_ready       = (state_q == ST_IDLE);
    assign bus.mem_rd          = (state_q == ST_ADDR);
    assign bus.mem_rdata_ready = (state_q == ST_DATA);
    assign bus.wb_valid        = (state_q == ST_WB);
    assign bus.mem_addr        = mem_addr_q;
    assign bus.wb_data         = wb_data_q;

endmodule

// File: tb/tb_load_align_unit.sv
// tb/tb_load_align_unit.sv - self-checking bench for load_align_unit
module tb_load_align_unit;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LWL = 6'h22;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] LWR = 6'h26;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_align_if #(.ADDR_W(32)) bus ();

    load_align_unit #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] m;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result computed with shifts and masks on whole words.
    function automatic logic [31:0] ref_model(input logic [5:0] op, input logic [1:0] ea,
                                              input logic [31:0] m, input logic [31:0] r);
        int          sh;
        int          hs;
        logic [31:0] b;
        logic [31:0] h;
        sh = 8 * int'(ea);
        hs = ea[1] ? 16 : 0;
        b  = (m >> sh) & 32'h0000_00FF;
        h  = (m >> hs) & 32'h0000_FFFF;
        case (op)
            LB:      return (b ^ 32'h80) - 32'h80;
            LBU:     return b;
            LH:      return (h ^ 32'h8000) - 32'h8000;
            LHU:     return h;
            LWL:     return (m << (24 - sh)) | (r & ((32'd1 << (24 - sh)) - 32'd1));
            LWR:     return (m >> sh) | (r & ~(32'hFFFF_FFFF >> sh));
            default: return m;
        endcase
    endfunction

    // One complete load: sa/sd/sw are stall cycles in the address, data and
    // writeback phases. Request inputs are scrambled right after acceptance
    // and junk read data is shown while in the address phase.
    task automatic do_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] r,
                           input logic [31:0] m, input int sa, input int sd, input int sw,
                           input logic [31:0] exp);
        logic [31:0] exp_ma;
        int          rd_cycles;
        exp_ma    = {a[31:2], 2'b00};
        rd_cycles = 0;
        bus.req_valid = 1'b1;
        bus.opcode    = op;
        bus.addr      = a;
        bus.rt_old    = r;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.opcode    = 6'($urandom);
        bus.addr      = $urandom;
        bus.rt_old    = $urandom;
        for (int i = 0; i <= sa; i++) begin
            bus.mem_addr_ready  = (i == sa);
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = $urandom;
            if (bus.mem_rd) rd_cycles++;
            chk("mem_addr", bus.mem_addr, exp_ma);
            chk("req_ready_addr", 32'(bus.req_ready), 32'd0);
            chk("rdata_ready_addr", 32'(bus.mem_rdata_ready), 32'd0);
            chk("wb_valid_addr", 32'(bus.wb_valid), 32'd0);
            @(negedge clk);
        end
        chk("mem_rd_cycles", 32'(rd_cycles), 32'(sa + 1));
        bus.mem_addr_ready = 1'b0;
        for (int i = 0; i <= sd; i++) begin
            bus.mem_rdata_valid = (i == sd);
            bus.mem_rdata       = (i == sd) ? m : $urandom;
            chk("rdata_ready", 32'(bus.mem_rdata_ready), 32'd1);
            chk("mem_rd_data", 32'(bus.mem_rd), 32'd0);
            chk("wb_valid_data", 32'(bus.wb_valid), 32'd0);
            @(negedge clk);
        end
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata       = $urandom;
        for (int i = 0; i <= sw; i++) begin
            bus.wb_ready = (i == sw);
            chk("wb_valid", 32'(bus.wb_valid), 32'd1);
            chk("wb_data", bus.wb_data, exp);
            chk("req_ready_wb", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.wb_ready = 1'b0;
        chk("wb_valid_after", 32'(bus.wb_valid), 32'd0);
    endtask

    initial begin
        logic [5:0]  op;
        logic [31:0] a, r, m;
        logic [5:0]  ops[8];

        checks = 0;
        errors = 0;

        vecs[0]  = '{LB,  32'h0000_1003, 32'h0,         32'h80FF_0000, 32'hFFFF_FF80};
        vecs[1]  = '{LHU, 32'h0000_2002, 32'h0,         32'h8001_1234, 32'h0000_8001};
        vecs[2]  = '{LH,  32'h0000_2003, 32'h0,         32'h8001_1234, 32'hFFFF_8001};
        vecs[3]  = '{LWL, 32'h0000_3001, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD};
        vecs[4]  = '{LWR, 32'h0000_3002, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122};
        vecs[5]  = '{LWL, 32'h0000_3000, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD};
        vecs[6]  = '{LWL, 32'h0000_3003, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};
        vecs[7]  = '{LWR, 32'h0000_3000, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344};
        vecs[8]  = '{LWR, 32'h0000_3003, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11};
        vecs[9]  = '{LBU, 32'h0000_4001, 32'h0,         32'h12AB_34CD, 32'h0000_0034};
        vecs[10] = '{LB,  32'h0000_4000, 32'h0,         32'h12AB_34CD, 32'hFFFF_FFCD};
        vecs[11] = '{LH,  32'h0000_4000, 32'h0,         32'h12AB_34CD, 32'h0000_34CD};
        vecs[12] = '{LW,  32'h0000_0042, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[13] = '{6'h0F, 32'h0000_5001, 32'h0,       32'h0102_0304, 32'h0102_0304};

        ops = '{LB, LBU, LH, LHU, LW, LWL, LWR, 6'h0F};

        rst = 1'b1;
        bus.req_valid       = 1'b0;
        bus.opcode          = '0;
        bus.addr            = '0;
        bus.rt_old          = '0;
        bus.mem_addr_ready  = 1'b0;
        bus.mem_rdata       = '0;
        bus.mem_rdata_valid = 1'b0;
        bus.wb_ready        = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("rst_rdata_ready", 32'(bus.mem_rdata_ready), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed vectors, all readies high (minimum latency)
        for (int i = 0; i < 14; i++) begin
            do_load(vecs[i].op, vecs[i].addr, vecs[i].rt, vecs[i].m, 0, 0, 0, vecs[i].exp);
        end

        // Long stalls in each phase
        do_load(LW, 32'h0000_3004, 32'h0, 32'h55AA_55AA, 5, 3, 4, 32'h55AA_55AA);

        // Reset while waiting for read data
        bus.req_valid = 1'b1;
        bus.opcode    = LW;
        bus.addr      = 32'h0000_0080;
        @(negedge clk);
        bus.req_valid      = 1'b0;
        bus.mem_addr_ready = 1'b1;
        @(negedge clk);
        bus.mem_addr_ready = 1'b0;
        chk("abort_in_data", 32'(bus.mem_rdata_ready), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_mem_rd", 32'(bus.mem_rd), 32'd0);
        chk("abort_rdata_ready", 32'(bus.mem_rdata_ready), 32'd0);
        chk("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        chk("abort_wb_data", bus.wb_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_rdata_ready", 32'(bus.mem_rdata_ready), 32'd0);
            chk("late_wb_valid", 32'(bus.wb_valid), 32'd0);
            chk("late_req_ready", 32'(bus.req_ready), 32'd1);
        end
        bus.mem_rdata_valid = 1'b0;
        do_load(LW, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D);

        // Back-to-back with req_valid held high and all readies high
        bus.req_valid       = 1'b1;
        bus.opcode          = LW;
        bus.addr            = 32'h0000_0100;
        bus.rt_old          = 32'h0;
        bus.mem_addr_ready  = 1'b1;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 32'h1357_9BDF;
        bus.wb_ready        = 1'b1;
        chk("b2b_accept_a", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.opcode = LB;
        bus.addr   = 32'h0000_0207;
        bus.rt_old = 32'hFFFF_FFFF;
        chk("b2b_mem_addr_a", bus.mem_addr, 32'h0000_0100);
        chk("b2b_mem_rd_a", 32'(bus.mem_rd), 32'd1);
        @(negedge clk);
        chk("b2b_data_a", 32'(bus.mem_rdata_ready), 32'd1);
        @(negedge clk);
        chk("b2b_wb_data_a", bus.wb_data, 32'h1357_9BDF);
        chk("b2b_req_ready_wb", 32'(bus.req_ready), 32'd0);
        bus.mem_rdata = 32'h7F00_0000;
        @(negedge clk);
        chk("b2b_accept_b", 32'(bus.req_ready), 32'd1);
        chk("b2b_wb_valid_idle", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("b2b_mem_addr_b", bus.mem_addr, 32'h0000_0204);
        chk("b2b_mem_rd_b", 32'(bus.mem_rd), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_wb_valid_b", 32'(bus.wb_valid), 32'd1);
        chk("b2b_wb_data_b", bus.wb_data, 32'h0000_007F);
        @(negedge clk);
        bus.mem_addr_ready  = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.wb_ready        = 1'b0;
        chk("b2b_idle", 32'(bus.req_ready), 32'd1);

        // Randomized loads against the reference model
        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 7)];
            a  = $urandom;
            r  = $urandom;
            m  = $urandom;
            do_load(op, a, r, m, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), ref_model(op, a[1:0], m, r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
